// File: rtl/pu_msp430_ram_master.sv
// ============================================================================
// Module   : pu_msp430_ram_master
// Purpose  : Valid/ready burst initiator for the pu_msp430 single-port RAM,
//            returning read words through a 4-entry FIFO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pu_msp430_ram_master #(
    parameter int ADDR_MSB = 6,
    parameter int MEM_SIZE = 256
) (
    input  logic                mclk,
    input  logic                puc_rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_MSB:0]   cmd_addr,
    input  logic [7:0]          cmd_len,
    input  logic [1:0]          cmd_be,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [15:0]         wr_data,
    output logic                rd_valid,
    input  logic                rd_ready,
    output logic [15:0]         rd_data,
    output logic                busy,
    output logic                err,
    output logic [ADDR_MSB:0]   ram_addr,
    output logic                ram_cen,
    output logic [1:0]          ram_wen,
    output logic [15:0]         ram_din,
    input  logic [15:0]         ram_dout
);

    localparam int unsigned         c_WORDS    = MEM_SIZE / 2;
    localparam logic [ADDR_MSB:0]   c_ADDR_ONE = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } state_t;

    state_t             state_q;
    logic [ADDR_MSB:0]  cur_addr_q;
    logic [7:0]         beats_left_q;
    logic [1:0]         be_q;
    logic               err_q;
    logic [ADDR_MSB:0]  ram_addr_q;
    logic               ram_cen_q;
    logic [1:0]         ram_wen_q;
    logic [15:0]        ram_din_q;
    logic               acc_v_q;
    logic               acc_rd_q;
    logic               acc_oor_q;
    logic               rd_pend_q;
    logic               pend_oor_q;

    logic [2:0]         fifo_cnt_q;
    logic [2:0]         fifo_cnt_d;
    logic [1:0]         wptr_q;
    logic [1:0]         rptr_q;
    logic [15:0]        fifo_q [4];

    logic               w_oor;
    logic               w_wr_beat;
    logic               w_rd_room;
    logic               w_rd_beat;
    logic               w_beat;
    logic               w_push;
    logic               w_pop;

    assign w_oor     = (32'(cur_addr_q) >= c_WORDS);
    assign w_wr_beat = (state_q == ST_WRITE) & wr_valid;
    // Reserve a FIFO slot for every read still travelling through the RAM pipe
    assign w_rd_room = (({1'b0, fifo_cnt_q} + {3'b000, acc_rd_q} + {3'b000, rd_pend_q}) < 4'd4);
    assign w_rd_beat = (state_q == ST_READ) & w_rd_room;
    assign w_beat    = w_wr_beat | w_rd_beat;
    assign w_push    = rd_pend_q;
    assign w_pop     = rd_valid & rd_ready;

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            state_q      <= ST_IDLE;
            cur_addr_q   <= '0;
            beats_left_q <= '0;
            be_q         <= '0;
            err_q        <= 1'b0;
            ram_addr_q   <= '0;
            ram_cen_q    <= 1'b1;
            ram_wen_q    <= 2'b11;
            ram_din_q    <= '0;
            acc_v_q      <= 1'b0;
            acc_rd_q     <= 1'b0;
            acc_oor_q    <= 1'b0;
            rd_pend_q    <= 1'b0;
            pend_oor_q   <= 1'b0;
        end else begin
            ram_cen_q  <= 1'b1;
            ram_wen_q  <= 2'b11;
            acc_v_q    <= w_beat;
            acc_rd_q   <= w_rd_beat;
            acc_oor_q  <= w_rd_beat & w_oor;
            rd_pend_q  <= acc_rd_q;
            pend_oor_q <= acc_oor_q;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        cur_addr_q   <= cmd_addr;
                        beats_left_q <= cmd_len;
                        be_q         <= cmd_be;
                        err_q        <= 1'b0;
                        state_q      <= cmd_write ? ST_WRITE : ST_READ;
                    end
                end
                default: begin
                    if (w_beat) begin
                        cur_addr_q   <= cur_addr_q + c_ADDR_ONE;
                        beats_left_q <= beats_left_q - 8'd1;
                        if (beats_left_q == 8'd0) begin
                            state_q <= ST_IDLE;
                        end
                        // Out-of-range beats still count, but never reach the RAM
                        if (w_oor) begin
                            err_q <= 1'b1;
                        end else if (w_rd_beat) begin
                            ram_cen_q  <= 1'b0;
                            ram_addr_q <= cur_addr_q;
                        end else if (be_q != 2'b00) begin
                            ram_cen_q  <= 1'b0;
                            ram_addr_q <= cur_addr_q;
                            ram_din_q  <= wr_data;
                            ram_wen_q  <= ~be_q;
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        fifo_cnt_d = fifo_cnt_q;
        case ({w_push, w_pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 3'd1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 3'd1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            fifo_cnt_q <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            for (int i = 0; i < 4; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            fifo_cnt_q <= fifo_cnt_d;
            if (w_push) begin
                fifo_q[wptr_q] <= pend_oor_q ? 16'h0000 : ram_dout;
                wptr_q         <= wptr_q + 2'd1;
            end
            if (w_pop) begin
                rptr_q <= rptr_q + 2'd1;
            end
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign wr_ready  = (state_q == ST_WRITE);
    assign rd_valid  = (fifo_cnt_q != 3'd0);
    assign rd_data   = fifo_q[rptr_q];
    assign busy      = (state_q != ST_IDLE) | acc_v_q | rd_pend_q;
    assign err       = err_q;
    assign ram_addr  = ram_addr_q;
    assign ram_cen   = ram_cen_q;
    assign ram_wen   = ram_wen_q;
    assign ram_din   = ram_din_q;

endmodule

`default_nettype wire

// File: tb/tb_pu_msp430_ram_master.sv
// ============================================================================
// Module   : tb_pu_msp430_ram_master
// Purpose  : Directed self-checking bench; instance A (7-bit addr) and B (8-bit
//            addr, 128 valid words) share stimulus, each with its own RAM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pu_msp430_ram_master;

    logic        mclk = 1'b0;
    logic        puc_rst = 1'b1;
    logic        ram_init = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_write = 1'b0;
    logic [7:0]  cmd_addr = '0;
    logic [7:0]  cmd_len = '0;
    logic [1:0]  cmd_be = '0;
    logic        wr_valid = 1'b0;
    logic [15:0] wr_data = '0;
    logic        rd_ready = 1'b1;

    logic        cmd_ready_a, wr_ready_a, rd_valid_a, busy_a, err_a, ram_cen_a;
    logic [15:0] rd_data_a, ram_din_a, ram_dout_a;
    logic [6:0]  ram_addr_a;
    logic [1:0]  ram_wen_a;
    logic        cmd_ready_b, wr_ready_b, rd_valid_b, busy_b, err_b, ram_cen_b;
    logic [15:0] rd_data_b, ram_din_b, ram_dout_b;
    logic [7:0]  ram_addr_b;
    logic [1:0]  ram_wen_b;

    logic [15:0] mem_a [128];
    logic [15:0] mem_b [256];

    typedef struct {
        int          cyc;
        logic [7:0]  addr;
        logic [1:0]  wen;
        logic [15:0] din;
    } acc_t;

    acc_t        acc_a[$];
    acc_t        acc_b[$];
    logic [15:0] rdq_a[$];
    logic [15:0] rdq_b[$];
    logic [15:0] wbuf [16];
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 mclk = ~mclk;

    pu_msp430_ram_master #(.ADDR_MSB(6), .MEM_SIZE(256)) u_dut_a (
        .mclk(mclk), .puc_rst(puc_rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_a), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr[6:0]), .cmd_len(cmd_len), .cmd_be(cmd_be),
        .wr_valid(wr_valid), .wr_ready(wr_ready_a), .wr_data(wr_data),
        .rd_valid(rd_valid_a), .rd_ready(rd_ready), .rd_data(rd_data_a),
        .busy(busy_a), .err(err_a),
        .ram_addr(ram_addr_a), .ram_cen(ram_cen_a), .ram_wen(ram_wen_a),
        .ram_din(ram_din_a), .ram_dout(ram_dout_a)
    );

    pu_msp430_ram_master #(.ADDR_MSB(7), .MEM_SIZE(256)) u_dut_b (
        .mclk(mclk), .puc_rst(puc_rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_b), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_be(cmd_be),
        .wr_valid(wr_valid), .wr_ready(wr_ready_b), .wr_data(wr_data),
        .rd_valid(rd_valid_b), .rd_ready(rd_ready), .rd_data(rd_data_b),
        .busy(busy_b), .err(err_b),
        .ram_addr(ram_addr_b), .ram_cen(ram_cen_b), .ram_wen(ram_wen_b),
        .ram_din(ram_din_b), .ram_dout(ram_dout_b)
    );

    // RAM models: registered-address read, low-active byte writes
    always @(posedge mclk) begin
        if (ram_init) begin
            for (int i = 0; i < 128; i++) mem_a[i] <= 16'hA000 | 16'(i);
            for (int i = 0; i < 256; i++) mem_b[i] <= 16'hB000 | 16'(i);
        end else begin
            if (!ram_cen_a) begin
                if (ram_wen_a == 2'b11) ram_dout_a <= mem_a[ram_addr_a];
                else begin
                    if (!ram_wen_a[0]) mem_a[ram_addr_a][7:0]  <= ram_din_a[7:0];
                    if (!ram_wen_a[1]) mem_a[ram_addr_a][15:8] <= ram_din_a[15:8];
                end
            end
            if (!ram_cen_b) begin
                if (ram_wen_b == 2'b11) ram_dout_b <= mem_b[ram_addr_b];
                else begin
                    if (!ram_wen_b[0]) mem_b[ram_addr_b][7:0]  <= ram_din_b[7:0];
                    if (!ram_wen_b[1]) mem_b[ram_addr_b][15:8] <= ram_din_b[15:8];
                end
            end
        end
    end

    always @(posedge mclk) begin
        if (!ram_cen_a) acc_a.push_back('{cyc, {1'b0, ram_addr_a}, ram_wen_a, ram_din_a});
        if (!ram_cen_b) acc_b.push_back('{cyc, ram_addr_b, ram_wen_b, ram_din_b});
        if (rd_valid_a && rd_ready) rdq_a.push_back(rd_data_a);
        if (rd_valid_b && rd_ready) rdq_b.push_back(rd_data_b);
        cyc = cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    task automatic clear_logs();
        acc_a.delete(); acc_b.delete(); rdq_a.delete(); rdq_b.delete();
    endtask

    task automatic chk_reset_state();
        chk("rst_cmd_ready", 32'(cmd_ready_a), 32'd1);
        chk("rst_wr_ready",  32'(wr_ready_a),  32'd0);
        chk("rst_rd_valid",  32'(rd_valid_a),  32'd0);
        chk("rst_rd_data",   32'(rd_data_a),   32'h0000);
        chk("rst_busy",      32'(busy_a),      32'd0);
        chk("rst_err",       32'(err_a),       32'd0);
        chk("rst_ram_cen",   32'(ram_cen_a),   32'd1);
        chk("rst_ram_wen",   32'(ram_wen_a),   32'h3);
        chk("rst_ram_addr",  32'(ram_addr_a),  32'h0);
        chk("rst_ram_din",   32'(ram_din_a),   32'h0);
    endtask

    task automatic send_cmd(input logic wr, input logic [7:0] a, input logic [7:0] n,
                            input logic [1:0] be);
        int t = 0;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = n; cmd_be = be;
        while (!cmd_ready_a && t < 50) begin tick(); t++; end
        if (!cmd_ready_a) chk("cmd_timeout", 32'(cmd_ready_a), 32'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic write_beats(input int n);
        for (int i = 0; i <= n; i++) begin
            wr_data = wbuf[i]; wr_valid = 1'b1; tick();
        end
        wr_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((busy_a || busy_b) && t < 100) begin tick(); t++; end
        if (busy_a) chk("idle_timeout", 32'(busy_a), 32'd0);
    endtask

    task automatic collect(input int n);
        int t = 0;
        while (rdq_a.size() < n && t < 200) begin tick(); t++; end
        chk("collect_count", 32'(rdq_a.size()), 32'(n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t;
        logic [15:0] exp8 [8];

        // Reset state
        tick(); tick();
        ram_init = 1'b0;
        chk_reset_state();
        puc_rst = 1'b0;
        tick();
        chk_reset_state();

        // Write burst 0x10..0x13, back-to-back
        clear_logs();
        wbuf[0] = 16'h1111; wbuf[1] = 16'h2222; wbuf[2] = 16'h3333; wbuf[3] = 16'h4444;
        send_cmd(1'b1, 8'h10, 8'd3, 2'b11);
        chk("wr_ready", 32'(wr_ready_a), 32'd1);
        write_beats(3);
        chk("wr_cmd_ready_after", 32'(cmd_ready_a), 32'd1);
        chk("wr_busy_tail", 32'(busy_a), 32'd1);
        tick();
        chk("wr_busy_fall", 32'(busy_a), 32'd0);
        chk("wr_acc_count", 32'(acc_a.size()), 32'd4);
        for (int i = 0; i < 4 && i < acc_a.size(); i++) begin
            chk("wr_addr", 32'(acc_a[i].addr), 32'h10 + 32'(i));
            chk("wr_wen",  32'(acc_a[i].wen),  32'h0);
            chk("wr_din",  32'(acc_a[i].din),  32'(wbuf[i]));
            chk("wr_consecutive", 32'(acc_a[i].cyc - acc_a[0].cyc), 32'(i));
        end

        // Read back with latency check
        clear_logs();
        rd_ready = 1'b1;
        send_cmd(1'b0, 8'h10, 8'd3, 2'b00);
        t = 0;
        while (!rd_valid_a && t < 20) begin tick(); t++; end
        chk("rd_first_latency", 32'(t), 32'd3);
        collect(4);
        wait_idle();
        for (int i = 0; i < 4 && i < rdq_a.size(); i++)
            chk("rd_data", 32'(rdq_a[i]), 32'(wbuf[i]));

        // Byte write over prior contents
        wbuf[0] = 16'h1234;
        send_cmd(1'b1, 8'h20, 8'd0, 2'b11);
        write_beats(0);
        wait_idle();
        clear_logs();
        wbuf[0] = 16'hABCD;
        send_cmd(1'b1, 8'h20, 8'd0, 2'b01);
        write_beats(0);
        wait_idle();
        chk("bw_acc_count", 32'(acc_a.size()), 32'd1);
        if (acc_a.size() > 0) chk("bw_wen", 32'(acc_a[0].wen), 32'h2);
        clear_logs();
        send_cmd(1'b0, 8'h20, 8'd0, 2'b00);
        collect(1);
        wait_idle();
        if (rdq_a.size() > 0) chk("bw_readback", 32'(rdq_a[0]), 32'h12CD);

        // Backpressure: 8-word read with rd_ready low
        clear_logs();
        rd_ready = 1'b0;
        send_cmd(1'b0, 8'h10, 8'd7, 2'b00);
        repeat (12) tick();
        chk("bp_issue_count", 32'(acc_a.size()), 32'd4);
        chk("bp_cen_idle", 32'(ram_cen_a), 32'd1);
        chk("bp_rd_valid", 32'(rd_valid_a), 32'd1);
        chk("bp_rd_head", 32'(rd_data_a), 32'h1111);
        rd_ready = 1'b1;
        collect(8);
        wait_idle();
        exp8 = '{16'h1111, 16'h2222, 16'h3333, 16'h4444,
                 16'hA014, 16'hA015, 16'hA016, 16'hA017};
        chk("bp_total_issues", 32'(acc_a.size()), 32'd8);
        for (int i = 0; i < 8 && i < rdq_a.size(); i++)
            chk("bp_data", 32'(rdq_a[i]), 32'(exp8[i]));
        chk("bp_no_extra", 32'(rdq_a.size()), 32'd8);

        // Out of range on instance B (128 valid words, 8-bit address)
        clear_logs();
        send_cmd(1'b0, 8'h7E, 8'd3, 2'b00);
        t = 0;
        while (rdq_b.size() < 4 && t < 100) begin tick(); t++; end
        wait_idle();
        chk("oor_count", 32'(rdq_b.size()), 32'd4);
        exp8[0] = 16'hB07E; exp8[1] = 16'hB07F; exp8[2] = 16'h0000; exp8[3] = 16'h0000;
        for (int i = 0; i < 4 && i < rdq_b.size(); i++)
            chk("oor_data", 32'(rdq_b[i]), 32'(exp8[i]));
        chk("oor_ram_access", 32'(acc_b.size()), 32'd2);
        chk("oor_err_set", 32'(err_b), 32'd1);
        chk("oor_err_a_clear", 32'(err_a), 32'd0);

        // Wrap on instance A; also clears B's sticky err on acceptance
        clear_logs();
        wbuf[0] = 16'hCAFE; wbuf[1] = 16'hBEEF;
        send_cmd(1'b1, 8'h7F, 8'd1, 2'b11);
        chk("err_clear_on_cmd", 32'(err_b), 32'd0);
        write_beats(1);
        wait_idle();
        chk("wrap_count", 32'(acc_a.size()), 32'd2);
        if (acc_a.size() > 1) begin
            chk("wrap_addr0", 32'(acc_a[0].addr), 32'h7F);
            chk("wrap_addr1", 32'(acc_a[1].addr), 32'h00);
        end
        chk("wrap_err", 32'(err_a), 32'd0);

        // Reset in the middle of a 16-word read
        clear_logs();
        send_cmd(1'b0, 8'h00, 8'd15, 2'b00);
        tick(); tick();
        #2 puc_rst = 1'b1;
        #1 chk_reset_state();
        tick(); tick();
        puc_rst = 1'b0;
        clear_logs();
        repeat (10) tick();
        chk("post_rst_no_access", 32'(acc_a.size()), 32'd0);
        chk("post_rst_busy", 32'(busy_a), 32'd0);
        chk("post_rst_no_data", 32'(rdq_a.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
